seq_digit_counter: RTL and testbench

- Parametrised successor of the lab digit-sequence output decoder.
- Contains its own index counter (up, down, stride, or hold-blank) and a parameter-defined digit sequence of configurable length and width.
- Drives a registered code `s` for the display decoder stage, plus a wrap pulse `tc` for cascading.
- Sits between the board button/switch logic and the 7-segment driver.

---
 rtl/seq_digit_counter.sv | 117 +++++++++++
 tb/tb_seq_digit_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_digit_counter.sv
// Index counter (up / down / stride / hold-blank) that drives a registered code
// taken from a parameter-defined digit sequence, plus a one-cycle wrap pulse.
module seq_digit_counter #(
    parameter int                 W     = 4,
    parameter int                 LEN   = 9,
    parameter int                 IW    = 4,
    parameter logic [LEN*W-1:0]   SEQ   = 36'h235646097,
    parameter int                 STEP  = 2,
    parameter logic [W-1:0]       BLANK = 4'hF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    UD,
    input  logic          ld,
    input  logic [IW-1:0] d,
    output logic [IW-1:0] idx,
    output logic [W-1:0]  s,
    output logic          tc
);

    localparam logic [IW-1:0] LAST   = IW'(LEN - 1);
    localparam logic [IW:0]   LEN_X  = (IW+1)'(LEN);
    localparam logic [IW:0]   STEP_X = (IW+1)'(STEP);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_STRIDE = 2'b10,
        MODE_BLANK  = 2'b11
    } mode_t;

    // Out-of-range indices fall back to entry 0 so no X can leak onto s.
    function automatic logic [W-1:0] seq_entry(input logic [IW-1:0] k);
        int ki;
        ki = int'(k);
        if (ki < LEN) begin
            seq_entry = SEQ[ki*W +: W];
        end else begin
            seq_entry = SEQ[W-1:0];
        end
    endfunction

    mode_t          mode_s;
    logic [IW-1:0]  idx_next_s;
    logic [W-1:0]   s_next_s;
    logic           tc_next_s;
    logic [IW:0]    sum_s;

    // Next index, wrap flag and output code from load/enable/mode.
    always_comb begin
        mode_s     = mode_t'(UD);
        idx_next_s = idx;
        tc_next_s  = 1'b0;
        sum_s      = {1'b0, idx} + STEP_X;
        if (ld) begin
            if ({1'b0, d} < LEN_X) begin
                idx_next_s = d;
            end else begin
                idx_next_s = LAST;
            end
        end else if (en && (mode_s != MODE_BLANK)) begin
            case (mode_s)
                MODE_UP: begin
                    if (idx >= LAST) begin
                        idx_next_s = {IW{1'b0}};
                        tc_next_s  = 1'b1;
                    end else begin
                        idx_next_s = idx + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                MODE_DOWN: begin
                    if (idx == {IW{1'b0}}) begin
                        idx_next_s = LAST;
                        tc_next_s  = 1'b1;
                    end else begin
                        idx_next_s = idx - {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                MODE_STRIDE: begin
                    if (sum_s >= LEN_X) begin
                        idx_next_s = IW'(sum_s - LEN_X);
                        tc_next_s  = 1'b1;
                    end else begin
                        idx_next_s = sum_s[IW-1:0];
                    end
                end
                default: begin
                    idx_next_s = idx;
                end
            endcase
        end else begin
            idx_next_s = idx;
        end

        // s follows the next index so idx and s always line up in the same cycle.
        if (mode_s == MODE_BLANK) begin
            s_next_s = BLANK;
        end else begin
            s_next_s = seq_entry(idx_next_s);
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= {IW{1'b0}};
            s   <= SEQ[W-1:0];
            tc  <= 1'b0;
        end else begin
            idx <= idx_next_s;
            s   <= s_next_s;
            tc  <= tc_next_s;
        end
    end

endmodule

// File: tb/tb_seq_digit_counter.sv
// Bench for seq_digit_counter: directed scenarios plus randomized traffic checked
// against an arithmetic (modulo) model of the digit sequence counter.
module tb_seq_digit_counter;

    localparam int LEN   = 9;
    localparam int STEP  = 2;
    localparam int BLANK = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] ud  = 2'b00;
    logic       ld  = 1'b0;
    logic [3:0] d   = 4'd0;
    logic [3:0] idx;
    logic [3:0] s;
    logic       tc;

    int vectors = 0;
    int errors  = 0;
    int seq_tbl [LEN] = '{7, 9, 0, 6, 4, 6, 5, 3, 2};
    int m_idx = 0;
    int m_s   = 7;
    int m_tc  = 0;

    seq_digit_counter dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .UD  (ud),
        .ld  (ld),
        .d   (d),
        .idx (idx),
        .s   (s),
        .tc  (tc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    // Advance the model one edge from the current inputs, then let the DUT take the edge.
    task automatic tick();
        int nidx;
        int ntc;
        nidx = m_idx;
        ntc  = 0;
        if (rst) begin
            nidx = 0;
        end else if (ld) begin
            nidx = (int'(d) < LEN) ? int'(d) : LEN - 1;
        end else if (en && ud != 2'b11) begin
            case (ud)
                2'b00: begin ntc = (m_idx + 1 >= LEN);    nidx = (m_idx + 1) % LEN; end
                2'b01: begin ntc = (m_idx == 0);          nidx = (m_idx + LEN - 1) % LEN; end
                2'b10: begin ntc = (m_idx + STEP >= LEN); nidx = (m_idx + STEP) % LEN; end
                default: ;
            endcase
        end
        if (rst)             m_s = seq_tbl[0];
        else if (ud == 2'b11) m_s = BLANK;
        else                  m_s = seq_tbl[nidx];
        m_idx = nidx;
        m_tc  = ntc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int exp_s [9] = '{9, 0, 6, 4, 6, 5, 3, 2, 7};
        rst = 1'b1; en = 1'b1; ud = 2'b00; ld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (idx !== 4'd0 || s !== 4'd7 || tc !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: idx=%0d s=%0h tc=%0b, expected idx=0 s=7 tc=0", idx, s, tc);
            end
        end
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            vectors++;
            if (s !== 4'(exp_s[k]) || tc !== (k == 8)) begin
                errors++;
                $display("FAIL up_seq[%0d]: s=%0h tc=%0b, expected s=%0h tc=%0b", k, s, tc, exp_s[k], (k == 8));
            end
        end
    endtask

    task automatic test_down();
        ud = 2'b01; en = 1'b1;
        tick();
        vectors++;
        if (idx !== 4'd8 || s !== 4'd2 || tc !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: idx=%0d s=%0h tc=%0b, expected idx=8 s=2 tc=1", idx, s, tc);
        end
        tick();
        vectors++;
        if (idx !== 4'd7 || s !== 4'd3 || tc !== 1'b0) begin
            errors++;
            $display("FAIL down_step: idx=%0d s=%0h tc=%0b, expected idx=7 s=3 tc=0", idx, s, tc);
        end
    endtask

    task automatic test_stride();
        int exp_i [3] = '{0, 2, 4};
        int exp_v [3] = '{7, 0, 4};
        ud = 2'b10; en = 1'b0; ld = 1'b1; d = 4'd7;
        tick();
        ld = 1'b0; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (idx !== 4'(exp_i[k]) || s !== 4'(exp_v[k]) || tc !== (k == 0)) begin
                errors++;
                $display("FAIL stride[%0d]: idx=%0d s=%0h tc=%0b, expected idx=%0d s=%0h tc=%0b",
                         k, idx, s, tc, exp_i[k], exp_v[k], (k == 0));
            end
        end
    endtask

    task automatic test_load();
        ud = 2'b00; en = 1'b0; ld = 1'b1; d = 4'd12;
        tick();
        vectors++;
        if (idx !== 4'd8 || s !== 4'd2 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: idx=%0d s=%0h tc=%0b, expected idx=8 s=2 tc=0", idx, s, tc);
        end
        en = 1'b1; d = 4'd3;
        tick();
        vectors++;
        if (idx !== 4'd3 || s !== 4'd6 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: idx=%0d s=%0h tc=%0b, expected idx=3 s=6 tc=0", idx, s, tc);
        end
        ld = 1'b0; en = 1'b0;
    endtask

    task automatic test_blank();
        ud = 2'b00; en = 1'b0; ld = 1'b1; d = 4'd5;
        tick();
        ld = 1'b0; ud = 2'b11;
        tick();
        vectors++;
        if (idx !== 4'd5 || s !== 4'hF || tc !== 1'b0) begin
            errors++;
            $display("FAIL blank_on: idx=%0d s=%0h tc=%0b, expected idx=5 s=f tc=0", idx, s, tc);
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (idx !== 4'd5 || s !== 4'hF || tc !== 1'b0) begin
                errors++;
                $display("FAIL blank_hold[%0d]: idx=%0d s=%0h tc=%0b, expected idx=5 s=f tc=0", k, idx, s, tc);
            end
        end
        en = 1'b0; ud = 2'b00;
        tick();
        vectors++;
        if (idx !== 4'd5 || s !== 4'd6) begin
            errors++;
            $display("FAIL blank_off: idx=%0d s=%0h, expected idx=5 s=6", idx, s);
        end
    endtask

    task automatic test_async_reset();
        ud = 2'b00; en = 1'b1; ld = 1'b1; d = 4'd8;
        tick();
        ld = 1'b0;
        tick();
        vectors++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_tc: tc=%0b, expected tc=1", tc);
        end
        ld = 1'b1; d = 4'd6; en = 1'b0;
        tick();
        ld = 1'b0; en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (idx !== 4'd0 || s !== 4'd7 || tc !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: idx=%0d s=%0h tc=%0b, expected idx=0 s=7 tc=0", idx, s, tc);
        end
        tick();
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            ld = ($urandom_range(0, 7) == 0);
            d  = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 3) != 0);
            ud = 2'($urandom_range(0, 3));
            tick();
            vectors++;
            if (idx !== 4'(m_idx) || s !== 4'(m_s) || tc !== 1'(m_tc)) begin
                errors++;
                $display("FAIL random[%0d]: idx=%0d s=%0h tc=%0b, expected idx=%0d s=%0h tc=%0b",
                         k, idx, s, tc, m_idx, m_s, m_tc);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_down();
        test_stride();
        test_load();
        test_blank();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
